// File: rtl/cpu_mux_pkg.sv
// Shared constants for the CPU stage-boundary select muxes.
// Used by mux_n_sel and pipe_mux_n; other stage muxes import it as well.
package cpu_mux_pkg;

  localparam int MUX_N_MAX = 16;

  // Fill bit for an out-of-range select: such a select yields an all-zero word.
  localparam logic SEL_OOR_BIT = 1'b0;

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way AND-OR select with one-hot decode of a binary select.
// A select value of N or above matches no source and returns the zero fill word.
module mux_n_sel
  import cpu_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0] src,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]   value
);

  localparam int NS = (N > MUX_N_MAX) ? MUX_N_MAX : N;

  logic [NS-1:0] hot;

  always_comb begin
    hot   = '0;
    value = {W{SEL_OOR_BIT}};
    for (int i = 0; i < NS; i++) begin
      hot[i] = (sel == SEL_W'(i));
      value  = value | (src[i*W +: W] & {W{hot[i]}});
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N-way select stage with valid/ready handshake, stall and flush.
// Define MUX_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_mux_n
  import cpu_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N*W-1:0]   src,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result
);

  logic [W-1:0] sel_word_p0;
  logic         push;
  logic         pop;
  logic [W-1:0] data_p1;
  logic         vld_p1;

  mux_n_sel #(.N(N), .W(W)) u_sel (
    .src   (src),
    .sel   (sel),
    .value (sel_word_p0)
  );

  assign push      = in_valid & in_ready;
  assign pop       = vld_p1 & out_ready;
  assign out_valid = vld_p1;
  assign result    = data_p1;

  // ---- p0 -> p1: stage register (and optional skid entry) ----
`ifdef MUX_SKID_EN
  logic [W-1:0] skid_data_p1;
  logic         skid_vld_p1;

  assign in_ready = resetn & ~skid_vld_p1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      data_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (pop && skid_vld_p1) begin
      data_p1     <= skid_data_p1;
      skid_vld_p1 <= push;
    end else if (push && vld_p1 && !pop) begin
      skid_vld_p1 <= 1'b1;
    end else if (push) begin
      data_p1 <= sel_word_p0;
      vld_p1  <= 1'b1;
    end else if (pop) begin
      vld_p1 <= 1'b0;
    end
  end

  // Skid contents only matter while skid_vld_p1 is set, and push is blocked
  // then, so loading on every accepted word never clobbers a live entry.
  always_ff @(posedge clk) begin
    if (push) skid_data_p1 <= sel_word_p0;
  end
`else
  assign in_ready = resetn & (~vld_p1 | out_ready);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (push) begin
      data_p1 <= sel_word_p0;
      vld_p1  <= 1'b1;
    end else if (pop) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

endmodule
